// File: rtl/mux2_stream_arbiter.sv
// Two-input round-robin stream arbiter feeding a MUX2x1 stage, with a one-entry
// registered output slot and per-source beat counters for bandwidth debug.

module mux2_stream_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 a_valid,
  input  logic [DATAWIDTH-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [DATAWIDTH-1:0] b_data,
  output logic                 b_ready,
  output logic                 sel,
  output logic                 d_valid,
  output logic [DATAWIDTH-1:0] d,
  output logic                 d_src,
  input  logic                 d_ready,
  output logic [CNTWIDTH-1:0]  cnt_a,
  output logic [CNTWIDTH-1:0]  cnt_b
);

  logic                 last_r;
  logic                 grant_s;
  logic                 load_s;
  logic                 accept_s;
  logic [DATAWIDTH-1:0] mux_s;

  function automatic logic [DATAWIDTH-1:0] mux2x1(
    input logic [DATAWIDTH-1:0] a,
    input logic [DATAWIDTH-1:0] b,
    input logic                 s
  );
    return s ? b : a;
  endfunction

  // Round-robin grant: a lone requester always wins, otherwise serve the one not served last.
  always_comb begin
    grant_s = ~last_r;
    case ({a_valid, b_valid})
      2'b10:   grant_s = 1'b0;
      2'b01:   grant_s = 1'b1;
      default: grant_s = ~last_r;
    endcase
  end

  // The slot can take a beat when empty or when its current beat drains this cycle.
  assign load_s   = ~d_valid | d_ready;
  assign a_ready  = load_s & a_valid & ~grant_s;
  assign b_ready  = load_s & b_valid & grant_s;
  assign accept_s = a_ready | b_ready;
  assign sel      = grant_s;
  assign mux_s    = mux2x1(a_data, b_data, grant_s);

  // Output slot and round-robin history.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      d_valid <= 1'b0;
      d       <= {DATAWIDTH{1'b0}};
      d_src   <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      if (accept_s) begin
        d       <= mux_s;
        d_src   <= grant_s;
        d_valid <= 1'b1;
        last_r  <= grant_s;
      end else if (load_s) begin
        d_valid <= 1'b0;
      end else begin
        d_valid <= d_valid;
      end
    end
  end

  // Per-source beat counters, wrapping modulo 2^CNTWIDTH.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_a <= {CNTWIDTH{1'b0}};
      cnt_b <= {CNTWIDTH{1'b0}};
    end else begin
      if (a_ready) begin
        cnt_a <= cnt_a + CNTWIDTH'(1);
      end else begin
        cnt_a <= cnt_a;
      end
      if (b_ready) begin
        cnt_b <= cnt_b + CNTWIDTH'(1);
      end else begin
        cnt_b <= cnt_b;
      end
    end
  end

  mux2_stream_arbiter_chk u_chk (
    .Clk     (Clk),
    .Rst     (Rst),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_ready (a_ready),
    .b_ready (b_ready)
  );

endmodule

// Handshake invariants of the arbiter's input side.
module mux2_stream_arbiter_chk (
  input logic Clk,
  input logic Rst,
  input logic a_valid,
  input logic b_valid,
  input logic a_ready,
  input logic b_ready
);

  ready_onehot: assert property (@(posedge Clk) disable iff (Rst) !(a_ready && b_ready));
  a_ready_needs_valid: assert property (@(posedge Clk) disable iff (Rst) (a_ready |-> a_valid));
  b_ready_needs_valid: assert property (@(posedge Clk) disable iff (Rst) (b_ready |-> b_valid));

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Scoreboard bench for mux2_stream_arbiter: stimulus pushes expected beats,
// a negedge monitor pops and compares each beat leaving the output slot.

module tb_mux2_stream_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       a_valid, b_valid, d_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, sel, d_valid, d_src;
  logic [7:0] d;
  logic [3:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];
  logic [3:0] ecnt_a = 4'd0;
  logic [3:0] ecnt_b = 4'd0;

  mux2_stream_arbiter #(.DATAWIDTH(8), .CNTWIDTH(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .d_valid(d_valid), .d(d), .d_src(d_src), .d_ready(d_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] data, input logic src);
    exp_q.push_back({src, data});
    if (src) ecnt_b = ecnt_b + 4'd1;
    else     ecnt_a = ecnt_a + 4'd1;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every beat leaving the slot must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (!Rst && d_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got d=%0h src=%0d, expected no beat", d, d_src);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("out_data", 32'(d), 32'(e[7:0]));
        chk("out_src", 32'(d_src), 32'(e[8]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; d_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    #6;
    chk("rst_dvalid", 32'(d_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_dsrc", 32'(d_src), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_readies", 32'({a_ready, b_ready}), 32'd0);
    #1;
    Rst = 1'b0;

    // Buffer a beat, then reset mid-cycle: it must vanish with no clock edge.
    a_valid = 1'b1; a_data = 8'hAB; d_ready = 1'b0;
    step();
    a_valid = 1'b0;
    chk("buf_dvalid", 32'(d_valid), 32'd1);
    #2;
    Rst = 1'b1;
    #1;
    chk("midrst_dvalid", 32'(d_valid), 32'd0);
    chk("midrst_cnt_a", 32'(cnt_a), 32'd0);
    chk("midrst_cnt_b", 32'(cnt_b), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    ecnt_a = 4'd0; ecnt_b = 4'd0;
    step();
    Rst = 1'b0;

    // Contention: A first, then strict alternation.
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; d_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("cont_sel", 32'(sel), 32'(i % 2));
      chk("cont_a_ready", 32'(a_ready), 32'((i % 2) == 0));
      push((i % 2) ? 8'h22 : 8'h11, 1'(i % 2));
      step();
    end
    chk("cont_cnt_a", 32'(cnt_a), 32'd3);
    chk("cont_cnt_b", 32'(cnt_b), 32'd3);
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Single source B, back-to-back.
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_data = 8'h5A + 8'(i);
      #1;
      chk("solo_b_ready", 32'(b_ready), 32'd1);
      chk("solo_a_ready", 32'(a_ready), 32'd0);
      push(8'h5A + 8'(i), 1'b1);
      step();
      chk("solo_latency", 32'({d_valid, d}), 32'({1'b1, 8'h5A + 8'(i)}));
    end
    b_valid = 1'b0;
    chk("solo_cnt_b", 32'(cnt_b), 32'd6);
    step();

    // Backpressure: 0x33 sits in the slot while B waits.
    d_ready = 1'b0; a_valid = 1'b1; a_data = 8'h33;
    #1;
    chk("bp_fill_ready", 32'(a_ready), 32'd1);
    push(8'h33, 1'b0);
    step();
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_b_ready", 32'(b_ready), 32'd0);
      chk("bp_hold", 32'({d_valid, d}), 32'({1'b1, 8'h33}));
      chk("bp_sel", 32'(sel), 32'd1);
      step();
    end
    d_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(b_ready), 32'd1);
    push(8'h44, 1'b1);
    step();
    chk("bp_reload", 32'({d_valid, d}), 32'({1'b1, 8'h44}));
    b_valid = 1'b0;
    step();

    // Valid drop: A requests during backpressure and withdraws without effect.
    b_valid = 1'b1; b_data = 8'h66;
    #1;
    push(8'h66, 1'b1);
    step();
    b_valid = 1'b0; d_ready = 1'b0; a_valid = 1'b1; a_data = 8'h77;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_a_ready", 32'(a_ready), 32'd0);
      step();
    end
    a_valid = 1'b0; d_ready = 1'b1;
    step();
    chk("drop_dvalid", 32'(d_valid), 32'd0);
    chk("drop_cnt_a", 32'(cnt_a), 32'(ecnt_a));
    chk("drop_cnt_a_abs", 32'(cnt_a), 32'd4);
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
    #1;
    chk("drop_sel_first", 32'(sel), 32'd0);
    push(8'h11, 1'b0);
    step();
    chk("drop_sel_second", 32'(sel), 32'd1);
    push(8'h22, 1'b1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Counter wrap with a 4-bit counter.
    Rst = 1'b1;
    #1;
    chk("wrap_rst_cnt_a", 32'(cnt_a), 32'd0);
    ecnt_a = 4'd0; ecnt_b = 4'd0;
    step();
    Rst = 1'b0;
    a_valid = 1'b1; d_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      a_data = 8'(k);
      #1;
      push(8'(k), 1'b0);
      step();
      if (k == 15) chk("wrap_cnt_15", 32'(cnt_a), 32'd15);
      if (k == 16) chk("wrap_cnt_16", 32'(cnt_a), 32'd0);
      if (k == 17) chk("wrap_cnt_17", 32'(cnt_a), 32'd1);
    end
    a_valid = 1'b0;
    step();
    step();
    chk("wrap_cnt_model", 32'(cnt_a), 32'(ecnt_a));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

Two-input round-robin stream arbiter that sits directly upstream of a MUX2x1 stage and generates its `sel`. It accepts beats from two valid/ready sources, picks one per cycle fairly, and captures the selected data into a one-entry output register with its own valid/ready handshake. It also keeps per-source transfer counters for bandwidth debug.

## Interface
- `DATAWIDTH`, 8: width of `a_data`, `b_data` and `d`.
- `CNTWIDTH`, 16: width of the per-source beat counters.

- `Clk` in 1: single clock; all state updates on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `a_valid` in 1: source A has a beat.
- `a_data` in DATAWIDTH: source A payload.
- `a_ready` out 1: source A beat is consumed this cycle.
- `b_valid` in 1: source B has a beat.
- `b_data` in DATAWIDTH: source B payload.
- `b_ready` out 1: source B beat is consumed this cycle.
- `sel` out 1: current grant, combinational. 0 selects A, 1 selects B. It drives the MUX2x1 `sel` input.
- `d_valid` out 1: output register holds a beat.
- `d` out DATAWIDTH: output payload (registered).
- `d_src` out 1: source of the beat in `d` (0 = A, 1 = B).
- `d_ready` in 1: downstream accepts `d` this cycle.
- `cnt_a` out CNTWIDTH: beats accepted from A.
- `cnt_b` out CNTWIDTH: beats accepted from B.

## Operation
- Internal state:
  - `last` (1 bit): the source served most recently.
  - The output register: `d_valid`, `d`, `d_src`.
  - `cnt_a` and `cnt_b`.
- `load = !d_valid || d_ready`: the output slot is empty, or it drains this cycle.
- Grant (combinational):
  - Both valid: grant = `~last` (round robin).
  - Only A valid: grant = 0.
  - Only B valid: grant = 1.
  - Neither valid: grant = `~last`.
- Output and ready signals:
  - `sel` = grant.
  - `a_ready = load & a_valid & ~grant`.
  - `b_ready = load & b_valid & grant`.
  - At most one of `a_ready` and `b_ready` is high in any cycle.
- Data path: an internal MUX2x1 (`a`=`a_data`, `b`=`b_data`, `sel`=grant) feeds the `d` register.
- Accept (`a_ready | b_ready`), at the next edge:
  - `d` ← mux output.
  - `d_src` ← grant.
  - `d_valid` ← 1.
  - `last` ← grant.
  - The granted counter increments by 1.
- `load` high with no accept: `d_valid` ← 0; `d` and `d_src` hold their last values.
- `load` low (`d_valid=1`, `d_ready=0`): `d`, `d_src`, `d_valid` and `last` all hold. Both readies are 0.
- Counters:
  - Unsigned; increment modulo 2^CNTWIDTH, so all-ones wraps to 0.
  - Change only on an accept from their own source.
- A source deasserting valid without being granted is legal and has no effect on state.

## Timing
- Reset values (applied asynchronously the moment `Rst` rises):
  - `d_valid`=0, `d`=0, `d_src`=0, `cnt_a`=0, `cnt_b`=0.
  - `last`=1, so A wins the first contention. With both inputs idle, `sel`=0 and both readies are 0.
- Reset mid-operation:
  - A buffered beat is discarded.
  - Counters clear.
  - Outputs take reset values with no clock edge needed.
  - The first accept is possible on the first rising edge after `Rst` falls.
- Latency: 1 cycle. A beat accepted at edge N shows `d_valid=1` with its data after edge N.
- Throughput: 1 beat/cycle while `d_ready=1`. A full slot that drains in cycle N accepts a new beat in the same cycle N (no bubble).
- Backpressure: with `d_ready=0` and `d_valid=1`, no input is consumed. `sel` may still change while both readies are 0.
- Fairness: with A and B continuously valid and `d_ready=1`, grants alternate A,B,A,B… A source waits at most 1 accepted beat of the other source.
- `sel` depends combinationally on `a_valid`, `b_valid` and `last` only. It has no combinational path from `d_ready`.

## Test plan
- Reset: assert `Rst` asynchronously mid-cycle with a beat buffered.
  - `d_valid`=0, `cnt_a`=`cnt_b`=0 and `sel`=0 immediately, before any clock edge.
  - After release, with both valid, A (0x11) is granted first.
- Contention: A=0x11 and B=0x22, both held valid, `d_ready`=1 for 6 cycles.
  - Output sequence is 0x11,0x22,0x11,0x22,0x11,0x22.
  - `d_src` alternates 0,1.
  - `cnt_a`=`cnt_b`=3.
- Single source: only B valid with 0x5A,0x5B,0x5C back-to-back.
  - `b_ready` is high each cycle.
  - Outputs arrive 1 cycle later, no gaps.
  - `cnt_b`=3, `a_ready` never high.
- Backpressure: fill the slot with A=0x33, then hold `d_ready`=0 for 4 cycles with B valid (0x44).
  - `d`=0x33 is held and `b_ready`=0 throughout.
  - Raise `d_ready`: 0x33 drains and 0x44 loads in the same cycle.
- Counter wrap: with CNTWIDTH=4, push 17 beats from A.
  - `cnt_a` reads 15 after 15 beats, 0 after 16 beats, 1 after 17 beats.
- Idle/valid drop: A raises valid while `d_ready`=0, then drops it before being granted.
  - No accept occurs, `cnt_a` is unchanged and `last` is unchanged (next contention follows the prior order).
